// File: rtl/hough_vote_accumulator_pkg.sv
// Shared definitions for the Hough vote accumulator: default geometry,
// bin-address width, FSM state encoding and the saturating count helper.
package hough_vote_accumulator_pkg;

  localparam int N_ANGLES = 45;
  localparam int R_OFFSET = 1024;
  localparam int R_SHIFT  = 3;
  localparam int BIN_AW   = 14;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SEARCH = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/hough_vote_accumulator_bin_ram.sv
// Bin counter memory: simple dual-port, registered read, no reset so it maps
// onto block RAM. Read returns the pre-write contents on an address collision.
module hough_bin_ram #(
  parameter int AW    = 14,
  parameter int DEPTH = 11520
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hough_vote_accumulator.sv
// Hough vote accumulator: 3-stage read-modify-write voting into 8-bit bins,
// with a full-memory clear and a lowest-address-wins peak search.
//
// state     | meaning
// CLEAR     | writing zero to every bin, one address per cycle
// ACCUM     | accepting votes, watching for clear/search commands
// DRAIN     | waiting for in-flight votes to land before the pending command
// SEARCH    | scanning every bin for the maximum count
module hough_vote_accumulator #(
  parameter int N_ANGLES = hough_vote_accumulator_pkg::N_ANGLES,
  parameter int R_OFFSET = hough_vote_accumulator_pkg::R_OFFSET,
  parameter int R_SHIFT  = hough_vote_accumulator_pkg::R_SHIFT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vote_valid,
  input  logic [12:0] vote_r,
  input  logic [5:0]  vote_angle_idx,
  output logic        vote_ready,
  input  logic        clear_start,
  input  logic        search_start,
  output logic        busy,
  output logic        search_done,
  output logic [7:0]  peak_count,
  output logic [5:0]  peak_angle_idx,
  output logic [7:0]  peak_r_bin
);
  import hough_vote_accumulator_pkg::*;

  localparam int DEPTH = N_ANGLES * 256;
  localparam logic [BIN_AW-1:0] LAST_ADDR = BIN_AW'(DEPTH - 1);

  state_t            state;
  logic [BIN_AW-1:0] cnt;
  logic              pend_clear;
  logic              srch_tail, srch_rd_v;
  logic [BIN_AW-1:0] srch_rd_addr, best_addr, nxt_best_addr;
  logic [7:0]        best_count, nxt_best_count;
  logic              cand_better;

  logic [13:0]       r_biased;
  logic [7:0]        r_bin;
  logic              vote_in_range, accept;
  logic [BIN_AW-1:0] vote_addr;

  logic              s1_valid, s2_valid, w3_valid;
  logic [BIN_AW-1:0] s1_addr, s2_addr, w3_addr;
  logic [7:0]        s2_count, w3_count, base_count;

  logic              ram_we;
  logic [BIN_AW-1:0] ram_waddr, ram_raddr;
  logic [7:0]        ram_wdata, ram_rdata;

  assign r_biased      = {vote_r[12], vote_r} + 14'(R_OFFSET);
  assign r_bin         = 8'(r_biased >> R_SHIFT);
  assign vote_addr     = {vote_angle_idx, r_bin};
  assign vote_in_range = 32'(vote_angle_idx) < N_ANGLES;
  assign accept        = vote_valid && vote_ready;

  // Newest in-flight count wins: stage 2 (not yet written), then the write
  // that landed in the same cycle the read was sampled.
  always_comb begin
    base_count = ram_rdata;
    if (s2_valid && s2_addr == s1_addr)      base_count = s2_count;
    else if (w3_valid && w3_addr == s1_addr) base_count = w3_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      w3_valid <= 1'b0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      w3_addr  <= '0;
      s2_count <= '0;
      w3_count <= '0;
    end else begin
      s1_valid <= accept && vote_in_range;
      s1_addr  <= vote_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_count <= sat_inc(base_count);
      w3_valid <= s2_valid;
      w3_addr  <= s2_addr;
      w3_count <= s2_count;
    end
  end

  assign ram_raddr = (state == ST_SEARCH) ? cnt : (vote_in_range ? vote_addr : '0);
  assign ram_we    = (state == ST_CLEAR) || s2_valid;
  assign ram_waddr = (state == ST_CLEAR) ? cnt : s2_addr;
  assign ram_wdata = (state == ST_CLEAR) ? 8'd0 : s2_count;

  hough_bin_ram #(.AW(BIN_AW), .DEPTH(DEPTH)) u_bin_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign cand_better    = srch_rd_v && (ram_rdata > best_count);
  assign nxt_best_count = cand_better ? ram_rdata : best_count;
  assign nxt_best_addr  = cand_better ? srch_rd_addr : best_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_CLEAR;
      cnt            <= '0;
      pend_clear     <= 1'b0;
      srch_tail      <= 1'b0;
      srch_rd_v      <= 1'b0;
      srch_rd_addr   <= '0;
      best_count     <= '0;
      best_addr      <= '0;
      vote_ready     <= 1'b0;
      busy           <= 1'b1;
      search_done    <= 1'b0;
      peak_count     <= '0;
      peak_angle_idx <= '0;
      peak_r_bin     <= '0;
    end else begin
      search_done <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (clear_start || search_start) begin
            state      <= ST_DRAIN;
            pend_clear <= clear_start;
            vote_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Stage 2 writes this cycle, so an empty stage 1 means memory is settled.
          if (!s1_valid) begin
            cnt        <= '0;
            best_count <= '0;
            best_addr  <= '0;
            srch_rd_v  <= 1'b0;
            srch_tail  <= 1'b0;
            state      <= pend_clear ? ST_CLEAR : ST_SEARCH;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            cnt        <= '0;
            state      <= ST_ACCUM;
            vote_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SEARCH: begin
          best_count <= nxt_best_count;
          best_addr  <= nxt_best_addr;
          if (!srch_tail) begin
            srch_rd_v    <= 1'b1;
            srch_rd_addr <= cnt;
            if (cnt == LAST_ADDR) srch_tail <= 1'b1;
            else                  cnt       <= cnt + 1'b1;
          end else begin
            srch_rd_v      <= 1'b0;
            srch_tail      <= 1'b0;
            cnt            <= '0;
            peak_count     <= nxt_best_count;
            peak_angle_idx <= nxt_best_addr[13:8];
            peak_r_bin     <= nxt_best_addr[7:0];
            search_done    <= 1'b1;
            state          <= ST_ACCUM;
            vote_ready     <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/hough_vote_accumulator.md
HOUGH_VOTE_ACCUMULATOR -- requirements
Module: hough_vote_accumulator

Interface
REQ-001 Parameter N_ANGLES, default 45, number of angle rows voted (angle_idx 0..44, angle = 4*angle_idx).
REQ-002 Parameter R_OFFSET, default 1024, bias added to signed r before binning.
REQ-003 Parameter R_SHIFT, default 3, right shift applied to biased r to form an 8-bit r_bin.
REQ-004 clk  input  1  sole clock; every register updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vote_valid  input  1  one vote presented this cycle.
REQ-007 vote_r  input  13  signed r from the transform stage (range -1024..1023).
REQ-008 vote_angle_idx  input  6  angle row of the vote.
REQ-009 vote_ready  output  1  high only in ACCUM with no command pending; votes offered while low are dropped.
REQ-010 clear_start  input  1  single-cycle pulse: zero all bins.
REQ-011 search_start  input  1  single-cycle pulse: scan all bins for the maximum.
REQ-012 busy  output  1  high in DRAIN, CLEAR and SEARCH.
REQ-013 search_done  output  1  single-cycle pulse when the peak outputs become valid.
REQ-014 peak_count  output  8  count of the winning bin.
REQ-015 peak_angle_idx  output  6  angle row of the winning bin.
REQ-016 peak_r_bin  output  8  r bin of the winning bin.

Function
REQ-017 Bin memory: N_ANGLES*256 entries of 8-bit counters, address = {angle_idx, r_bin}; one read port, one write port, 1-cycle read latency.
REQ-018 r_bin = (vote_r + R_OFFSET) >> R_SHIFT, computed 14 bits wide, low 8 bits kept.
REQ-019 A vote with vote_angle_idx >= N_ANGLES is accepted but discarded (no memory write).
REQ-020 States: CLEAR, ACCUM, DRAIN, SEARCH; encoding free.
REQ-021 Vote pipeline: cycle 0 accept and read, cycle 1 data returns, cycle 2 write count+1; sustained throughput one vote per cycle.
REQ-022 Counters saturate at 255; no wrap.
REQ-023 Hazards: a vote hitting the same address as a vote 1 or 2 cycles earlier uses the forwarded in-flight count; no increment is lost.
REQ-024 ACCUM: clear_start -> DRAIN then CLEAR; search_start -> DRAIN then SEARCH; both in same cycle -> clear wins, search ignored.
REQ-025 A vote accepted in the same cycle as a command is counted before the command acts.
REQ-026 DRAIN lasts until the vote pipeline is empty (at most 2 cycles), then enters the pending state.
REQ-027 CLEAR writes zero to addresses 0..N_ANGLES*256-1, one per cycle (11520 cycles), then ACCUM.
REQ-028 SEARCH reads addresses 0..N_ANGLES*256-1 sequentially; a candidate replaces the running peak only if strictly greater, so the lowest address wins ties.
REQ-029 Peak outputs update and search_done pulses exactly once, 2 cycles after the last read is issued; state returns to ACCUM in that cycle.
REQ-030 All-zero memory: search reports count 0, angle_idx 0, r_bin 0.
REQ-031 Commands arriving while busy are ignored.
REQ-032 Peak outputs hold their last values until the next search completes.

Reset
REQ-033 Reset enters CLEAR at address 0, flushes the vote pipeline, and sets vote_ready=0, busy=1, search_done=0, peak_count=0, peak_angle_idx=0, peak_r_bin=0.
REQ-034 Reset mid-CLEAR, mid-SEARCH or mid-vote restarts the full clear; no partial result or search_done is emitted.

Structure
REQ-035 Shared package holds the state encoding, N_ANGLES, R_OFFSET, R_SHIFT and the bin-address width (14).
REQ-036 Bin memory is one sub-module, hough_bin_ram (simple dual-port, sync read), inferable as block RAM.

Verification
REQ-037 Reset, wait 11520 cycles -> busy falls, vote_ready=1; search -> peak_count=0, angle 0, r_bin 0.
REQ-038 Five back-to-back votes r=0, angle_idx=3, then search -> peak_count=5, angle_idx=3, r_bin=128 (forwarding check).
REQ-039 Alternate votes A(r=-8,idx 1), B(r=16,idx 2) x4 each, search -> count 4, idx 1, r_bin 127 (tie, lower address wins).
REQ-040 300 votes r=1023, idx 44 -> peak_count=255, angle_idx 44, r_bin 255 (saturation).
REQ-041 Vote in same cycle as clear_start and search_start -> clear runs, search never completes, subsequent search reports 0.
REQ-042 Reset asserted mid-SEARCH -> no search_done; full 11520-cycle clear, then prior votes absent.
